max6682_mean_sensor_fsm: RTL and testbench
==========================================

# max6682_mean_sensor_fsm

Upstream controller for the MAX6682 SPI transfer FSM. On every expiry of a programmable period timer it issues 2^NUM_SAMPLES_LOG2 back-to-back read requests to the SPI FSM. It collects each two-byte result and averages the samples. When the mean differs from the last reported value by more than a threshold, it stores the mean and pulses a CPU interrupt.

## Interface
- NUM_SAMPLES_LOG2, default 2, log2 of samples per measurement burst (legal 0..4)
- Clk_i  in  1  system clock, rising edge
- Reset_i  in  1  asynchronous, active-high reset
- Enable_i  in  1  level; 1 = periodic measurement running
- PeriodCounterPresetH_i  in  16  upper half of 32-bit period preset
- PeriodCounterPresetL_i  in  16  lower half of 32-bit period preset
- Threshold_i  in  16  unsigned change threshold
- SPI_FSM_Start_o  out  1  one-cycle request to SPI FSM
- SPI_FSM_Done_i  in  1  one-cycle completion from SPI FSM; bytes valid in same cycle
- Byte0_i  in  8  low result byte
- Byte1_i  in  8  high result byte
- SensorValue_o  out  16  last reported mean
- CpuIntr_o  out  1  one-cycle interrupt pulse

## Operation
- Sample extraction: raw = {Byte1_i, Byte0_i}; sample = {5'b0, raw[15:5]} (11-bit, zero-extended).
- Accumulator is 16+NUM_SAMPLES_LOG2 bits; no overflow possible. Mean = accumulator >> NUM_SAMPLES_LOG2, low 16 bits.
- Change test: absolute difference |mean − SensorValue_o|, unsigned 16-bit. Report only if diff > Threshold_i (strict).
- Timer: 32-bit down-counter, loaded with {H,L} whenever the FSM is in stDisabled and on each expiry. It decrements only in stIdle. Expiry = count 0 in stIdle.
- States:
  - stDisabled: counter reload, accumulator/sample count cleared. Enable_i=1 → stIdle.
  - stIdle: Enable_i=0 → stDisabled. Counter 0 → reload, → stStart.
  - stStart: SPI_FSM_Start_o=1 (decoded from state register only, never from Done_i). Always → stWait.
  - stWait: on Done_i: accumulator += sample, count++. If Enable_i=0 → stDisabled, data discarded. Else, if last sample → stCompare; otherwise → stStart.
  - stCompare: evaluate change test. If report: SensorValue_o ← mean, CpuIntr_o ← 1. Clear accumulator/count. → stIdle.
- Disable while in stStart/stWait is honoured only after Done_i, so the SPI FSM never loses its partner mid-transfer.
- Done_i outside stWait is ignored.

## Timing
- Reset: state stDisabled, SPI_FSM_Start_o=0, SensorValue_o=0, CpuIntr_o=0, counter=0, accumulator=0, count=0.
- Start pulse width exactly 1 cycle. Start is never high in a cycle where Done_i is sampled, so the SPI FSM returns to idle after each transfer.
- Expiry (counter 0 in stIdle) → Start high on the next cycle.
- Done of the last sample → stCompare on the next cycle. CpuIntr_o and SensorValue_o update on the edge that leaves stCompare, so they are visible 2 cycles after Done.
- Period between burst starts = preset+1 idle cycles + burst duration. Preset 0 → burst starts on the cycle after entering stIdle.
- Reset mid-burst: immediate return to reset values; partial accumulation is lost.

## Structure
- Shared package max6682_mean_pkg: state encoding constants (stDisabled, stIdle, stStart, stWait, stCompare), sample bit-offset constant (5), sample width (11).
- One sub-module: sensor_period_timer, the 32-bit loadable down-counter with reload, enable and zero flag.
- Main FSM and datapath (accumulator, absolute difference, compare) stay in this module.

## Test plan
- Reset: hold Reset_i mid-stWait → all outputs 0, state stDisabled. Release with Enable_i=0 → no Start.
- Basic burst, NUM_SAMPLES_LOG2=2, preset 10, Threshold 5, SPI model returns Byte1=0x19 Byte0=0x00 (sample 200) four times:
  - first Start 11 cycles after entering stIdle;
  - exactly 4 Start pulses;
  - SensorValue_o=200, CpuIntr_o one-cycle pulse 2 cycles after the 4th Done.
- No-change: repeat with samples 203 → diff 3 ≤ 5 → no interrupt, SensorValue_o stays 200. Samples 206 → diff 6 → interrupt, value 206.
- Averaging/truncation: samples 100,101,101,101 → mean 100 (403>>2). Max samples 0xFFFF raw (2047) ×4 → mean 2047, no overflow.
- Disable mid-burst: drop Enable_i during stWait of 2nd sample → no further Start after that Done, no interrupt, accumulator cleared. Re-enable → fresh 4-sample burst after full period.
- Spurious Done_i in stIdle → ignored, accumulator unchanged, timer unaffected.

Source files
------------

// File: rtl/max6682_mean_pkg.sv
// ---------------------------------------------------------------------------
// max6682_mean_pkg
// Shared definitions for the MAX6682 mean-sensor controller:
//   - state_t       : controller state encoding
//   - SAMPLE_LSB    : bit offset of the temperature field inside the raw word
//   - SAMPLE_WIDTH  : width of the temperature field
//   - abs_diff()    : unsigned 16-bit absolute difference helper
// ---------------------------------------------------------------------------
package max6682_mean_pkg;

  typedef enum logic [2:0] {
    stDisabled = 3'd0,
    stIdle     = 3'd1,
    stStart    = 3'd2,
    stWait     = 3'd3,
    stCompare  = 3'd4
  } state_t;

  localparam int unsigned SAMPLE_LSB   = 5;
  localparam int unsigned SAMPLE_WIDTH = 11;

  function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sensor_period_timer.sv
// ---------------------------------------------------------------------------
// sensor_period_timer
// 32-bit loadable down-counter that paces measurement bursts.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset (count -> 0)
//   load    in   load preset (has priority over counting)
//   enable  in   decrement by one per cycle while nonzero
//   preset  in   32-bit reload value
//   zero    out  count is zero (expiry flag)
// ---------------------------------------------------------------------------
module sensor_period_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        enable,
  input  logic [31:0] preset,
  output logic        zero
);

  logic [31:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= preset;
    end else if (enable && !zero) begin
      // Saturates at zero; the controller reloads on expiry.
      count <= count - 32'd1;
    end
  end

  assign zero = (count == 32'd0);

endmodule

// File: rtl/max6682_mean_sensor_fsm.sv
// ---------------------------------------------------------------------------
// max6682_mean_sensor_fsm
// Periodically requests 2^NUM_SAMPLES_LOG2 back-to-back readings from the
// MAX6682 SPI transfer FSM, averages them, and when the mean moves by more
// than Threshold_i from the last reported value, stores it and pulses an
// interrupt.
// Ports:
//   Clk_i                   in   clock, rising edge
//   Reset_i                 in   asynchronous active-high reset
//   Enable_i                in   1 = periodic measurement running
//   PeriodCounterPresetH_i  in   upper 16 bits of period preset
//   PeriodCounterPresetL_i  in   lower 16 bits of period preset
//   Threshold_i             in   unsigned change threshold
//   SPI_FSM_Start_o         out  one-cycle transfer request
//   SPI_FSM_Done_i          in   one-cycle completion, bytes valid same cycle
//   Byte0_i / Byte1_i       in   low / high result byte
//   SensorValue_o           out  last reported mean
//   CpuIntr_o               out  one-cycle interrupt pulse
// ---------------------------------------------------------------------------
module max6682_mean_sensor_fsm
  import max6682_mean_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES_LOG2 = 2
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        Enable_i,
  input  logic [15:0] PeriodCounterPresetH_i,
  input  logic [15:0] PeriodCounterPresetL_i,
  input  logic [15:0] Threshold_i,
  output logic        SPI_FSM_Start_o,
  input  logic        SPI_FSM_Done_i,
  input  logic [7:0]  Byte0_i,
  input  logic [7:0]  Byte1_i,
  output logic [15:0] SensorValue_o,
  output logic        CpuIntr_o
);

  // 11-bit samples summed 2^N times never exceed 16+N bits.
  localparam int unsigned ACC_W = 16 + NUM_SAMPLES_LOG2;
  localparam int unsigned CNT_W = NUM_SAMPLES_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << NUM_SAMPLES_LOG2) - 1);

  state_t state;
  state_t state_next;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] sample_cnt;
  logic [15:0]      sensor_value;
  logic             cpu_intr;

  logic             timer_load;
  logic             timer_run;
  logic             timer_zero;

  logic [15:0]      raw;
  logic [15:0]      sample;
  logic             raw_unused;
  logic [15:0]      mean;
  logic [15:0]      diff;
  logic             report;
  logic             last_sample;

  // -------------------------------------------------------------------------
  // Datapath decode
  // -------------------------------------------------------------------------
  assign raw        = {Byte1_i, Byte0_i};
  assign sample     = {{(16 - SAMPLE_WIDTH){1'b0}}, raw[SAMPLE_LSB +: SAMPLE_WIDTH]};
  // Low status bits of the MAX6682 word carry no temperature information.
  assign raw_unused = ^raw[SAMPLE_LSB-1:0];

  assign mean        = acc[NUM_SAMPLES_LOG2 +: 16];
  assign diff        = abs_diff(mean, sensor_value);
  assign report      = (diff > Threshold_i);
  assign last_sample = (sample_cnt == LAST_SAMPLE);

  // -------------------------------------------------------------------------
  // Period timer
  // -------------------------------------------------------------------------
  sensor_period_timer u_timer (
    .clk    (Clk_i),
    .rst    (Reset_i),
    .load   (timer_load),
    .enable (timer_run),
    .preset ({PeriodCounterPresetH_i, PeriodCounterPresetL_i}),
    .zero   (timer_zero)
  );

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state <= stDisabled;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // A disable request is only acted upon once the running transfer has
  // completed, so the SPI FSM is never abandoned mid-transfer.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      stDisabled: if (Enable_i) state_next = stIdle;
      stIdle: begin
        if (!Enable_i)       state_next = stDisabled;
        else if (timer_zero) state_next = stStart;
      end
      stStart: state_next = stWait;
      stWait: begin
        if (SPI_FSM_Done_i) begin
          if (!Enable_i)        state_next = stDisabled;
          else if (last_sample) state_next = stCompare;
          else                  state_next = stStart;
        end
      end
      stCompare: state_next = stIdle;
      default:   state_next = stDisabled;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register only)
  // -------------------------------------------------------------------------
  always_comb begin
    SPI_FSM_Start_o = (state == stStart);
    timer_load      = (state == stDisabled) || ((state == stIdle) && timer_zero);
    timer_run       = (state == stIdle);
  end

  // -------------------------------------------------------------------------
  // Accumulator, sample counter and reported value
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      acc          <= '0;
      sample_cnt   <= '0;
      sensor_value <= '0;
      cpu_intr     <= 1'b0;
    end else begin
      cpu_intr <= 1'b0;
      case (state)
        stDisabled: begin
          acc        <= '0;
          sample_cnt <= '0;
        end
        stWait: begin
          if (SPI_FSM_Done_i) begin
            acc        <= acc + ACC_W'(sample);
            sample_cnt <= sample_cnt + CNT_W'(1);
          end
        end
        stCompare: begin
          if (report) begin
            sensor_value <= mean;
            cpu_intr     <= 1'b1;
          end
          acc        <= '0;
          sample_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign SensorValue_o = sensor_value;
  assign CpuIntr_o     = cpu_intr;

endmodule

// File: tb/tb_max6682_mean_sensor_fsm.sv
// ---------------------------------------------------------------------------
// tb_max6682_mean_sensor_fsm
// Directed self-checking bench for max6682_mean_sensor_fsm with a small
// SPI FSM model answering every Start with a Done two cycles later.
// ---------------------------------------------------------------------------
module tb_max6682_mean_sensor_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] preset_h;
  logic [15:0] preset_l;
  logic [15:0] thr;
  logic        start;
  logic        done;
  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic [15:0] sval;
  logic        intr;

  logic        mdl_done  = 1'b0;
  logic        spur_done = 1'b0;
  logic [15:0] mdl_raw   = 16'h0000;
  logic [15:0] spur_raw  = 16'h0000;
  logic [15:0] raw_tab [4];

  assign done           = mdl_done | spur_done;
  assign {byte1, byte0} = spur_done ? spur_raw : mdl_raw;

  max6682_mean_sensor_fsm #(.NUM_SAMPLES_LOG2(2)) dut (
    .Clk_i                  (clk),
    .Reset_i                (rst),
    .Enable_i               (en),
    .PeriodCounterPresetH_i (preset_h),
    .PeriodCounterPresetL_i (preset_l),
    .Threshold_i            (thr),
    .SPI_FSM_Start_o        (start),
    .SPI_FSM_Done_i         (done),
    .Byte0_i                (byte0),
    .Byte1_i                (byte1),
    .SensorValue_o          (sval),
    .CpuIntr_o              (intr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle stamps of every observed Start-high, Done and interrupt-high cycle.
  int start_q[$];
  int done_q[$];
  int intr_q[$];

  int errors = 0;
  int checks = 0;
  int base_s, base_d, base_i;

  // Output monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (start === 1'b1) start_q.push_back(cyc);
      if (intr === 1'b1)  intr_q.push_back(cyc);
    end
  end

  // SPI FSM model: Done two cycles after a Start is seen.
  int mdl_delay = 0;
  bit mdl_busy  = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      mdl_done = 1'b0;
      if (mdl_busy) begin
        mdl_delay--;
        if (mdl_delay == 0) begin
          mdl_raw  = raw_tab[(done_q.size() - base_d) & 3];
          mdl_done = 1'b1;
          done_q.push_back(cyc);
          mdl_busy = 1'b0;
        end
      end else if (start === 1'b1) begin
        mdl_busy  = 1'b1;
        mdl_delay = 2;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic mark();
    base_s = start_q.size();
    base_d = done_q.size();
    base_i = intr_q.size();
  endtask

  // Wait (bounded) for n Done pulses since mark(), then settle 3 cycles.
  task automatic wait_done(input string tag, input int n);
    int k;
    k = 0;
    while ((done_q.size() - base_d) < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_timeout"}, 32'(done_q.size() - base_d), 32'(n));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_starts(input string tag, input int n);
    int k;
    k = 0;
    while ((start_q.size() - base_s) < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_start_timeout"}, 32'(start_q.size() - base_s), 32'(n));
  endtask

  // One full 4-sample burst. With do_en the controller is enabled from
  // stDisabled (first Start 12 stamps later: 1 to enter stIdle + 11 idle);
  // otherwise the burst follows the previous one (13 stamps after its last
  // Done: compare, 11 idle cycles, start).
  task automatic run_burst(input string tag, input logic [15:0] r0, input logic [15:0] r1,
                           input logic [15:0] r2, input logic [15:0] r3, input bit do_en,
                           input int exp_val, input int exp_intr);
    int refc;
    int gap;
    raw_tab[0] = r0; raw_tab[1] = r1; raw_tab[2] = r2; raw_tab[3] = r3;
    mark();
    if (do_en) begin
      en   = 1'b1;
      refc = cyc;
      gap  = 12;
    end else begin
      refc = done_q[done_q.size() - 1];
      gap  = 13;
    end
    wait_done(tag, 4);
    if (start_q.size() > base_s)
      check({tag, "_first_start_gap"}, 32'(start_q[base_s] - refc), 32'(gap));
    check({tag, "_start_pulses"}, 32'(start_q.size() - base_s), 32'd4);
    check({tag, "_value"}, {16'h0, sval}, 32'(exp_val));
    check({tag, "_intr_cycles"}, 32'(intr_q.size() - base_i), 32'(exp_intr));
    if (exp_intr == 1 && intr_q.size() > base_i)
      check({tag, "_intr_latency"}, 32'(intr_q[base_i] - done_q[base_d + 3]), 32'd2);
    $display("burst %s: value=%0d intr_cycles=%0d starts=%0d", tag, sval,
             intr_q.size() - base_i, start_q.size() - base_s);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    preset_h = 16'd0; preset_l = 16'd10; thr = 16'd5;
    raw_tab[0] = 16'h0; raw_tab[1] = 16'h0; raw_tab[2] = 16'h0; raw_tab[3] = 16'h0;
    base_s = 0; base_d = 0; base_i = 0;

    // Reset values, then stay idle while disabled.
    repeat (3) @(negedge clk);
    check("reset_start", {31'h0, start}, 32'd0);
    check("reset_value", {16'h0, sval}, 32'd0);
    check("reset_intr",  {31'h0, intr}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("disabled_no_start", 32'(start_q.size()), 32'd0);
    $display("reset/disabled: starts=%0d value=%0d", start_q.size(), sval);

    // Bursts with hand-computed means (threshold 5, sample = raw[15:5]).
    run_burst("b200", 16'h1900, 16'h1900, 16'h1900, 16'h1900, 1'b1, 200, 1);
    run_burst("b203", 16'h1967, 16'h1967, 16'h1967, 16'h1967, 1'b0, 200, 0);
    run_burst("b206", 16'h19C0, 16'h19C0, 16'h19C0, 16'h19C0, 1'b0, 206, 1);
    run_burst("trunc", 16'h0C80, 16'h0CA0, 16'h0CA0, 16'h0CA0, 1'b0, 100, 1);
    run_burst("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 2047, 1);
    run_burst("diff_eq_thr", 16'hFF40, 16'hFF40, 16'hFF40, 16'hFF40, 1'b0, 2047, 0);

    // Spurious Done while idle: no accumulation, timer keeps its pace.
    spur_raw  = 16'hFFFF;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    run_burst("after_spurious", 16'h7D00, 16'h7D00, 16'h7D00, 16'h7D00, 1'b0, 1000, 1);

    // Disable during the second transfer.
    raw_tab[0] = 16'h7D00; raw_tab[1] = 16'h7D00; raw_tab[2] = 16'h7D00; raw_tab[3] = 16'h7D00;
    mark();
    wait_starts("disable", 2);
    en = 1'b0;
    repeat (40) @(negedge clk);
    check("disable_starts", 32'(start_q.size() - base_s), 32'd2);
    check("disable_dones",  32'(done_q.size() - base_d), 32'd2);
    check("disable_intr",   32'(intr_q.size() - base_i), 32'd0);
    check("disable_value",  {16'h0, sval}, 32'd1000);
    $display("disable mid-burst: starts=%0d dones=%0d value=%0d",
             start_q.size() - base_s, done_q.size() - base_d, sval);
    run_burst("reenable", 16'h3E80, 16'h3E80, 16'h3E80, 16'h3E80, 1'b1, 500, 1);

    // Reset while waiting for a transfer.
    mark();
    wait_starts("reset_mid", 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_start", {31'h0, start}, 32'd0);
    check("midreset_value", {16'h0, sval}, 32'd0);
    check("midreset_intr",  {31'h0, intr}, 32'd0);
    en  = 1'b0;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midreset_no_restart", 32'(start_q.size() - base_s), 32'd1);
    $display("reset mid-wait: value=%0d starts=%0d", sval, start_q.size() - base_s);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
